// File: rtl/iagc_mem_sequencer.sv
// -----------------------------------------------------------------------------
// iagc_mem_sequencer
//
// Walks the reference / error sample memories on behalf of the IAGC control
// FSM. A dump command reads every active word and streams it to the transmit
// path over a valid/ready handshake. A clean command writes zero to every
// active word of both memories. Completion is reported with single-cycle
// dump-end / clean-end pulses.
//
// All outputs are registered: the output process computes the value each
// output register takes on the next edge from the current state and the
// state being entered.
// -----------------------------------------------------------------------------
module iagc_mem_sequencer #(
  parameter int                      STATUS_SIZE  = 4,
  parameter int                      ADDR_SIZE    = 12,
  parameter int                      DATA_SIZE    = 14,
  parameter logic [STATUS_SIZE-1:0]  ST_DUMP_REF  = 4'b0111,
  parameter logic [STATUS_SIZE-1:0]  ST_DUMP_ERR  = 4'b1000,
  parameter logic [STATUS_SIZE-1:0]  ST_CLEAN_MEM = 4'b1001
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [STATUS_SIZE-1:0] i_status,
  input  logic [ADDR_SIZE-1:0]   i_memory_size,
  output logic                   o_mem_sel,
  output logic [ADDR_SIZE-1:0]   o_mem_addr,
  output logic                   o_mem_rd_en,
  input  logic [DATA_SIZE-1:0]   i_mem_rd_data,
  output logic                   o_mem_wr_en,
  output logic [DATA_SIZE-1:0]   o_mem_wr_data,
  output logic [DATA_SIZE-1:0]   o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_dump_end,
  output logic                   o_clean_end
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAN,
    S_DUMP_RD,
    S_DUMP_WAIT,
    S_DUMP_TX,
    S_DONE
  } state_t;

  // Current state and registered bookkeeping.
  state_t                 state_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [ADDR_SIZE-1:0]   last_q;     // last address of the running operation
  logic [STATUS_SIZE-1:0] op_q;       // status code that started the operation

  // Next-cycle values.
  state_t                 state_d;
  logic [ADDR_SIZE-1:0]   addr_d;
  logic [ADDR_SIZE-1:0]   last_d;
  logic [STATUS_SIZE-1:0] op_d;
  logic                   sel_d;
  logic                   rd_en_d;
  logic                   wr_en_d;
  logic [DATA_SIZE-1:0]   tx_data_d;
  logic                   tx_valid_d;
  logic                   dump_end_d;
  logic                   clean_end_d;

  // Decoded conditions shared by the next-state and output processes.
  logic start_clean;
  logic start_dump;
  logic op_held;
  logic at_last;
  logic tx_accept;
  logic leaving_idle;

  assign start_clean  = (i_status == ST_CLEAN_MEM);
  assign start_dump   = (i_status == ST_DUMP_REF) || (i_status == ST_DUMP_ERR);
  // Once an operation is running, any other status code (including another
  // memory command) aborts it back to IDLE; the new command starts from there.
  assign op_held      = (i_status == op_q);
  assign at_last      = (addr_q == last_q);
  assign tx_accept    = o_tx_valid && i_tx_ready;
  assign leaving_idle = (state_q == S_IDLE) && (state_d != S_IDLE);

  assign o_mem_addr    = addr_q;
  assign o_mem_wr_data = '0;

  // State register and all registered outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      last_q      <= '0;
      op_q        <= '0;
      o_mem_sel   <= 1'b0;
      o_mem_rd_en <= 1'b0;
      o_mem_wr_en <= 1'b0;
      o_tx_data   <= '0;
      o_tx_valid  <= 1'b0;
      o_dump_end  <= 1'b0;
      o_clean_end <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      op_q        <= op_d;
      o_mem_sel   <= sel_d;
      o_mem_rd_en <= rd_en_d;
      o_mem_wr_en <= wr_en_d;
      o_tx_data   <= tx_data_d;
      o_tx_valid  <= tx_valid_d;
      o_dump_end  <= dump_end_d;
      o_clean_end <= clean_end_d;
    end
  end

  // Next-state decision: command decode in IDLE, walk / handshake otherwise.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no
    // latch is inferred when a branch leaves the signal untouched.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_clean)     state_d = S_CLEAN;
        else if (start_dump) state_d = S_DUMP_RD;
      end
      S_CLEAN: begin
        if (!op_held)     state_d = S_IDLE;
        else if (at_last) state_d = S_DONE;
      end
      S_DUMP_RD: begin
        state_d = op_held ? S_DUMP_WAIT : S_IDLE;
      end
      S_DUMP_WAIT: begin
        state_d = op_held ? S_DUMP_TX : S_IDLE;
      end
      S_DUMP_TX: begin
        if (!op_held)      state_d = S_IDLE;
        else if (tx_accept) state_d = at_last ? S_DONE : S_DUMP_RD;
      end
      S_DONE: begin
        // Holding here while the status is unchanged stops the same command
        // from being restarted during the control FSM's transition cycle.
        if (!op_held) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath values for the next cycle, derived from the transition.
  always_comb begin
    addr_d      = addr_q;
    last_d      = last_q;
    op_d        = op_q;
    sel_d       = o_mem_sel;
    tx_data_d   = o_tx_data;

    // Strobes follow the state being entered so they line up with it.
    rd_en_d     = (state_d == S_DUMP_RD);
    wr_en_d     = (state_d == S_CLEAN);
    tx_valid_d  = (state_d == S_DUMP_TX);
    dump_end_d  = (state_q == S_DUMP_TX) && (state_d == S_DONE);
    clean_end_d = (state_q == S_CLEAN)   && (state_d == S_DONE);

    // Operation parameters are frozen when leaving IDLE; a size of zero wraps
    // to an all-ones last address, i.e. the full address space.
    if (leaving_idle) begin
      op_d   = i_status;
      last_d = i_memory_size - ADDR_SIZE'(1);
      if (start_dump) sel_d = (i_status == ST_DUMP_ERR);
    end

    // Address walk: cleared around IDLE, advanced only on a completed word.
    if (state_q == S_IDLE || state_d == S_IDLE) begin
      addr_d = '0;
    end else if (state_q == S_CLEAN && state_d == S_CLEAN) begin
      addr_d = addr_q + ADDR_SIZE'(1);
    end else if (state_q == S_DUMP_TX && state_d == S_DUMP_RD) begin
      addr_d = addr_q + ADDR_SIZE'(1);
    end

    // Read data arrives the cycle after the strobe, i.e. while in DUMP_WAIT;
    // it is only kept if the dump is still running.
    if (state_q == S_DUMP_WAIT && state_d == S_DUMP_TX) begin
      tx_data_d = i_mem_rd_data;
    end
  end

  // Structural invariants of the registered outputs.
  a_rd_wr_exclusive : assert property (@(posedge i_clock) disable iff (!i_reset)
    !(o_mem_rd_en && o_mem_wr_en));
  a_end_exclusive   : assert property (@(posedge i_clock) disable iff (!i_reset)
    !(o_dump_end && o_clean_end));

endmodule
